// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: FSM states, opcodes, funct codes, ULA op/control encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    ADDIEX  = 4'd8,
    ADDIWB  = 4'd9,
    BEQEX   = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ULAOP_ADD   = 2'b00,
    ULAOP_SUB   = 2'b01,
    ULAOP_FUNCT = 2'b10
  } ulaop_t;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // Per-state control word; ula_en zeroes ULAcontrol in states that don't use the ULA.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       ula_en;
    ulaop_t     ulaop;
  } ctrl_t;

endpackage

// File: rtl/ula_decoder.sv
// Combinational ULAop + funct -> ULAcontrol decode, shared with the single-cycle controller.
module ula_decoder
  import mips_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ULA_W   = 3
) (
  input  ulaop_t             ulaop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ULA_W-1:0]   ulacontrol
);

  logic [2:0] code;

  always_comb begin
    code = ULA_ADD;
    case (ulaop)
      ULAOP_ADD: code = ULA_ADD;
      ULAOP_SUB: code = ULA_SUB;
      ULAOP_FUNCT: begin
        // Unknown funct quietly falls back to add.
        case (funct)
          FUNCT_W'(F_ADD): code = ULA_ADD;
          FUNCT_W'(F_SUB): code = ULA_SUB;
          FUNCT_W'(F_AND): code = ULA_AND;
          FUNCT_W'(F_OR):  code = ULA_OR;
          FUNCT_W'(F_SLT): code = ULA_SLT;
          default:         code = ULA_ADD;
        endcase
      end
      default: code = ULA_ADD;
    endcase
  end

  assign ulacontrol = ULA_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with optional memory-ready handshake.
// Define MULTICYCLE_JUMP_EN to decode opcode 000010 as a jump (JEX state).
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int FUNCT_W       = 6,
  parameter int ULA_W         = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               irwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               ULAsrcA,
  output logic [1:0]         ULAsrcB,
  output logic [1:0]         pcsrc,
  output logic [ULA_W-1:0]   ULAcontrol,
  output logic               illegal_op
);

  state_t           state, state_nx;
  ctrl_t            c, cg;
  logic             mem_ok;
  logic             op_legal;
  logic             illegal_s;
  logic [ULA_W-1:0] dec_out;

  assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    op_legal = (op == OP_W'(OP_LW))    || (op == OP_W'(OP_SW))  ||
               (op == OP_W'(OP_RTYPE)) || (op == OP_W'(OP_BEQ)) ||
               (op == OP_W'(OP_ADDI));
`ifdef MULTICYCLE_JUMP_EN
    op_legal = op_legal || (op == OP_W'(OP_J));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:   state_nx = mem_ok ? DECODE : FETCH;
      DECODE: begin
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_nx = MEMADR;
        else if (op == OP_W'(OP_RTYPE))               state_nx = RTYPEEX;
        else if (op == OP_W'(OP_BEQ))                 state_nx = BEQEX;
        else if (op == OP_W'(OP_ADDI))                state_nx = ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
        else if (op == OP_W'(OP_J))                   state_nx = JEX;
`endif
        else                                          state_nx = FETCH;
      end
      MEMADR:  state_nx = (op == OP_W'(OP_SW)) ? MEMWR : MEMRD;
      MEMRD:   state_nx = mem_ok ? MEMWB : MEMRD;
      MEMWR:   state_nx = mem_ok ? FETCH : MEMWR;
      RTYPEEX: state_nx = RTYPEWB;
      ADDIEX:  state_nx = ADDIWB;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    c         = '0;
    illegal_s = 1'b0;
    case (state)
      FETCH: begin
        c.memread = 1'b1;
        c.irwrite = mem_ok;
        c.pcwrite = mem_ok;
        c.srcb    = 2'b01;
        c.ula_en  = 1'b1;
        c.ulaop   = ULAOP_ADD;
      end
      DECODE: begin
        c.srcb    = 2'b11;
        c.ula_en  = 1'b1;
        c.ulaop   = ULAOP_ADD;
        illegal_s = !op_legal;
      end
      MEMADR, ADDIEX: begin
        c.srca   = 1'b1;
        c.srcb   = 2'b10;
        c.ula_en = 1'b1;
        c.ulaop  = ULAOP_ADD;
      end
      MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.srca   = 1'b1;
        c.ula_en = 1'b1;
        c.ulaop  = ULAOP_FUNCT;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      ADDIWB: c.regwrite = 1'b1;
      BEQEX: begin
        c.srca   = 1'b1;
        c.ula_en = 1'b1;
        c.ulaop  = ULAOP_SUB;
        c.branch = 1'b1;
        c.pcsrc  = 2'b01;
      end
`ifdef MULTICYCLE_JUMP_EN
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
`endif
      default: c = '0;
    endcase
  end

  ula_decoder #(.FUNCT_W(FUNCT_W), .ULA_W(ULA_W)) u_ula_decoder (
    .ulaop      (c.ulaop),
    .funct      (funct),
    .ulacontrol (dec_out)
  );

  // While reset is held the FSM sits in FETCH, but every strobe must read 0.
  assign cg = reset ? '0 : c;

  assign pcen       = cg.pcwrite | (cg.branch & zero);
  assign iord       = cg.iord;
  assign irwrite    = cg.irwrite;
  assign memread    = cg.memread;
  assign memwrite   = cg.memwrite;
  assign regwrite   = cg.regwrite;
  assign regdst     = cg.regdst;
  assign memtoreg   = cg.memtoreg;
  assign ULAsrcA    = cg.srca;
  assign ULAsrcB    = cg.srcb;
  assign pcsrc      = cg.pcsrc;
  assign ULAcontrol = cg.ula_en ? dec_out : '0;
  assign illegal_op = illegal_s & ~reset;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 states (more with memory wait states) and drives the shared-memory multicycle datapath. It replaces the single-cycle controller when the datapath shares one memory and one ULA across cycles. It extends the single-cycle instruction set (R-type add/sub/and/or/slt, lw, sw, beq) with addi, an optional jump, a memory-ready handshake and illegal-opcode reporting.

## Interface
- OP_W, 6: opcode width.
- FUNCT_W, 6: funct field width.
- ULA_W, 3: ULAcontrol width; codes are zero-extended if wider than 3.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, memory completes in one cycle.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- op  in  OP_W  opcode from instruction register.
- funct  in  FUNCT_W  funct field from instruction register.
- zero  in  1  ULA zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pcen  out  1  PC write enable = pcwrite | (branch & zero).
- iord  out  1  memory address source: 0 = PC, 1 = ULAout.
- irwrite  out  1  instruction register load.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  destination select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = MDR, 0 = ULAout.
- ULAsrcA  out  1  ULA A input: 0 = PC, 1 = register A.
- ULAsrcB  out  2  ULA B input: 00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  PC source: 00 = ULA result, 01 = ULAout, 10 = jump target.
- ULAcontrol  out  ULA_W  ULA operation.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States and transitions:
  - FETCH -> DECODE.
  - DECODE, by op:
    - lw/sw -> MEMADR.
    - R-type -> RTYPEEX.
    - beq -> BEQEX.
    - addi -> ADDIEX.
    - j -> JEX.
    - anything else -> FETCH, with illegal_op.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
- Memory states are FETCH, MEMRD and MEMWR. With MEM_HANDSHAKE=1 each one holds, outputs unchanged, until mem_ready=1. irwrite and pcwrite assert only in the FETCH cycle where mem_ready=1.
- Outputs are a pure function of state, except:
  - pcen, which uses zero.
  - ULAcontrol in RTYPEEX, which uses funct.
  - the FETCH gating by mem_ready.
- Any output not listed for a state is 0.
- FETCH: memread, irwrite, ULAsrcB=01, ULAop add, pcwrite.
- DECODE: ULAsrcB=11, ULAop add (branch target precompute).
- MEMADR and ADDIEX: ULAsrcA=1, ULAsrcB=10, add.
- MEMRD: iord, memread.
- MEMWB: regwrite, memtoreg.
- MEMWR: iord, memwrite.
- RTYPEEX: ULAsrcA=1, ULAop funct.
- RTYPEWB: regdst, regwrite.
- ADDIWB: regwrite.
- BEQEX: ULAsrcA=1, sub, branch, pcsrc=01.
- JEX: pcsrc=10, pcwrite.
- ULAcontrol decode:
  - add = 010, sub = 110.
  - funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010; no illegal_op pulse.
- Unsupported opcode: illegal_op=1 during the DECODE cycle, no register or memory write, then return to FETCH.

## Timing
- Instruction latency with mem_ready always 1:
  - lw 5 cycles.
  - sw, R-type and addi 4 cycles.
  - beq and j 3 cycles.
- Each cycle with mem_ready=0 in a memory state adds one cycle.
- beq is taken iff zero=1 in the BEQEX cycle; pcen follows zero in that same cycle.
- Reset asserted: state = FETCH immediately (asynchronous) and every output forced to 0, including irwrite, memread, pcen and illegal_op.
- Reset released: FETCH outputs appear in the first cycle; the first transition happens on the first rising edge with reset low.
- Reset mid-instruction abandons it; no further regwrite or memwrite is issued for that instruction.
- If the state register ever holds an unencoded value, the FSM goes to FETCH on the next edge.

## Configuration
- MULTICYCLE_JUMP_EN defined: opcode 000010 decodes to JEX (3 cycles, pcsrc=10).
- Undefined: JEX is not compiled; opcode 000010 is illegal (illegal_op pulse, return to FETCH), and pcsrc never equals 10.

## Structure
- Package mips_pkg:
  - state enum state_t.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - funct constants.
  - ULAop typedef (add, sub, funct).
  - ULAcontrol code constants.
- Sub-module ula_decoder: combinational ULAop + funct -> ULAcontrol. It is shared with the single-cycle controller.

## Test plan
- lw (op 100011), mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; ULAcontrol=010 in MEMADR.
- R-type slt (funct 101010): ULAcontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in cycle 4; back to FETCH in cycle 5.
- beq: with zero=1 in BEQEX, pcen=1 and pcsrc=01; repeat with zero=0, pcen=0; both take 3 cycles.
- MEM_HANDSHAKE=1, mem_ready low for 3 cycles in FETCH then high: irwrite pulses once, on cycle 4; pcen pulses once.
- Opcode 111111: illegal_op=1 for exactly the DECODE cycle; regwrite=0 and memwrite=0 throughout; FETCH next. Repeat with opcode 000010 without MULTICYCLE_JUMP_EN.
- Reset asserted in MEMWR: memwrite drops to 0 asynchronously; after release, FETCH outputs (memread=1, irwrite=1) appear.
